rv32i_program_writer: RTL and testbench

Front-end program loader: the encode-side counterpart of the RV32I decode path. It accepts symbolic instructions (mnemonic, register fields, immediate) over a valid/ready stream and range-checks each one. Legal instructions are encoded into 32-bit RV32I words and written to instruction memory at consecutive word addresses. It sits between the test/boot host interface and the instruction memory write port in `fe`.

---
 rtl/fe_pkg.sv | 69 ++++++
 rtl/rv32i_program_writer_encoder.sv | 107 ++++++++++
 rtl/rv32i_program_writer.sv | 91 +++++++++
 tb/tb_rv32i_program_writer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fe_pkg.sv
// Front-end shared types: RV32I mnemonics, opcodes and the program-writer encodings.
package fe_pkg;

    typedef logic [4:0]  RV32I_REGISTER_t;
    typedef logic [31:0] RV32I_IMM_t;

    typedef enum logic [5:0] {
        NULL,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
        SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ECALL, EBREAK
    } RV32I_INSTRUCTION_MNEMONIC_t;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_IMM    = 7'b0010011,
        OPC_REG    = 7'b0110011,
        OPC_SYSTEM = 7'b1110011
    } RV32I_OPCODE_t;

    typedef enum logic [1:0] {IDLE, RUN, FULL} RV32I_WRITER_STATE_t;

    // Instruction layout classes used by the encoder.
    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS
    } RV32I_FORMAT_t;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    // Load/store width funct3
    localparam logic [2:0] F3_B    = 3'd0;
    localparam logic [2:0] F3_H    = 3'd1;
    localparam logic [2:0] F3_W    = 3'd2;
    localparam logic [2:0] F3_BU   = 3'd4;
    localparam logic [2:0] F3_HU   = 3'd5;
    localparam logic [2:0] F3_JALR = 3'd0;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [31:0] ECALL_WORD  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

endpackage

// File: rtl/rv32i_program_writer_encoder.sv
// Combinational RV32I encoder: symbolic fields in, 32-bit word and range-check flag out.
module rv32i_encoder
    import fe_pkg::*;
(
    input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
    input  RV32I_REGISTER_t             rd,
    input  RV32I_REGISTER_t             rs1,
    input  RV32I_REGISTER_t             rs2,
    input  RV32I_IMM_t                  imm,
    output logic [31:0]                 word,
    output logic                        illegal
);

    RV32I_FORMAT_t fmt;
    RV32I_OPCODE_t opc;
    logic [2:0]    f3;
    logic [6:0]    f7;
    logic          bad_op;

    // Decode mnemonic into format, opcode and function fields.
    always_comb begin
        fmt    = FMT_R;
        opc    = OPC_REG;
        f3     = F3_ADD;
        f7     = F7_BASE;
        bad_op = 1'b0;
        case (mnemonic)
            LUI:    begin fmt = FMT_U; opc = OPC_LUI;   end
            AUIPC:  begin fmt = FMT_U; opc = OPC_AUIPC; end
            JAL:    begin fmt = FMT_J; opc = OPC_JAL;   end
            JALR:   begin fmt = FMT_I; opc = OPC_JALR; f3 = F3_JALR; end
            BEQ:    begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BEQ;  end
            BNE:    begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BNE;  end
            BLT:    begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLT;  end
            BGE:    begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGE;  end
            BLTU:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BLTU; end
            BGEU:   begin fmt = FMT_B; opc = OPC_BRANCH; f3 = F3_BGEU; end
            LB:     begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_B;  end
            LH:     begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_H;  end
            LW:     begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_W;  end
            LBU:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_BU; end
            LHU:    begin fmt = FMT_I; opc = OPC_LOAD; f3 = F3_HU; end
            SB:     begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_B; end
            SH:     begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_H; end
            SW:     begin fmt = FMT_S; opc = OPC_STORE; f3 = F3_W; end
            ADDI:   begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_ADD;  end
            SLTI:   begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_SLT;  end
            SLTIU:  begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_SLTU; end
            XORI:   begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_XOR;  end
            ORI:    begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_OR;   end
            ANDI:   begin fmt = FMT_I; opc = OPC_IMM; f3 = F3_AND;  end
            SLLI:   begin fmt = FMT_SH; opc = OPC_IMM; f3 = F3_SLL; end
            SRLI:   begin fmt = FMT_SH; opc = OPC_IMM; f3 = F3_SR;  end
            SRAI:   begin fmt = FMT_SH; opc = OPC_IMM; f3 = F3_SR; f7 = F7_ALT; end
            ADD:    f3 = F3_ADD;
            SUB:    begin f3 = F3_ADD; f7 = F7_ALT; end
            SLL:    f3 = F3_SLL;
            SLT:    f3 = F3_SLT;
            SLTU:   f3 = F3_SLTU;
            XOR:    f3 = F3_XOR;
            SRL:    f3 = F3_SR;
            SRA:    begin f3 = F3_SR; f7 = F7_ALT; end
            OR:     f3 = F3_OR;
            AND:    f3 = F3_AND;
            ECALL:  begin fmt = FMT_SYS; opc = OPC_SYSTEM; end
            EBREAK: begin fmt = FMT_SYS; opc = OPC_SYSTEM; end
            default: bad_op = 1'b1;
        endcase
    end

    // Assemble the word for the selected format and flag out-of-range immediates.
    // A value fits an N-bit signed field when bits [31:N-1] are all equal.
    always_comb begin
        word    = 32'h0;
        illegal = bad_op;
        unique case (fmt)
            FMT_R: word = {f7, rs2, rs1, f3, rd, opc};
            FMT_I: begin
                word    = {imm[11:0], rs1, f3, rd, opc};
                illegal = bad_op || !(&imm[31:11] || ~|imm[31:11]);
            end
            FMT_SH: begin
                word    = {f7, imm[4:0], rs1, f3, rd, opc};
                illegal = bad_op || |imm[31:5];
            end
            FMT_S: begin
                word    = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                illegal = bad_op || !(&imm[31:11] || ~|imm[31:11]);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                illegal = bad_op || imm[0] || !(&imm[31:12] || ~|imm[31:12]);
            end
            FMT_U: begin
                word    = {imm[31:12], rd, opc};
                illegal = bad_op || |imm[11:0];
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                illegal = bad_op || imm[0] || !(&imm[31:20] || ~|imm[31:20]);
            end
            FMT_SYS: word = (mnemonic == EBREAK) ? EBREAK_WORD : ECALL_WORD;
            default: word = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv32i_program_writer.sv
// Program loader: encodes accepted instructions and writes them to consecutive imem words.
module rv32i_program_writer
    import fe_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_WIDTH = 10,
    parameter int unsigned BASE_ADDR       = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  RV32I_INSTRUCTION_MNEMONIC_t in_mnemonic,
    input  RV32I_REGISTER_t             in_rd,
    input  RV32I_REGISTER_t             in_rs1,
    input  RV32I_REGISTER_t             in_rs2,
    input  RV32I_IMM_t                  in_imm,
    output logic                        imem_we,
    input  logic                        imem_ready,
    output logic [IMEM_ADDR_WIDTH-1:0]  imem_addr,
    output logic [31:0]                 imem_wdata,
    output logic                        err_illegal,
    output logic                        full,
    output logic [IMEM_ADDR_WIDTH:0]    word_count
);

    localparam logic [IMEM_ADDR_WIDTH-1:0] BASE_PTR = IMEM_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [IMEM_ADDR_WIDTH-1:0] LAST_PTR = {IMEM_ADDR_WIDTH{1'b1}};

    RV32I_WRITER_STATE_t        state;
    logic [IMEM_ADDR_WIDTH-1:0] ptr;
    logic [31:0]                enc_word;
    logic                       enc_illegal;
    logic                       accept;

    rv32i_encoder u_encoder (
        .mnemonic (in_mnemonic),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .imm      (in_imm),
        .word     (enc_word),
        .illegal  (enc_illegal)
    );

    // Single output slot that can refill in the cycle it drains; start blocks intake.
    always_comb begin
        in_ready = (state == RUN) && !start && (!imem_we || imem_ready);
        accept   = in_valid && in_ready;
    end

    // FSM, write pointer, counter and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= BASE_PTR;
            imem_we     <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= 32'h0;
            err_illegal <= 1'b0;
            full        <= 1'b0;
            word_count  <= '0;
        end else begin
            err_illegal <= accept && enc_illegal;
            if (imem_we && imem_ready) begin
                imem_we <= 1'b0;
            end
            if (accept && !enc_illegal) begin
                imem_we    <= 1'b1;
                imem_addr  <= ptr;
                imem_wdata <= enc_word;
                word_count <= word_count + 1'b1;
                // The pointer parks on the last address instead of wrapping.
                if (ptr == LAST_PTR) begin
                    state <= FULL;
                    full  <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end
            // Never coincides with accept; a pending write keeps its latched address.
            if (start) begin
                state      <= RUN;
                full       <= 1'b0;
                ptr        <= BASE_PTR;
                word_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_program_writer.sv
// Directed bench for rv32i_program_writer with a write scoreboard (4-word imem).
module tb_rv32i_program_writer;
    import fe_pkg::*;

    localparam int unsigned AW = 2;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        start = 1'b0;
    logic                        in_valid = 1'b0;
    logic                        in_ready;
    RV32I_INSTRUCTION_MNEMONIC_t in_mnemonic = NULL;
    RV32I_REGISTER_t             in_rd = '0;
    RV32I_REGISTER_t             in_rs1 = '0;
    RV32I_REGISTER_t             in_rs2 = '0;
    RV32I_IMM_t                  in_imm = '0;
    logic                        imem_we;
    logic                        imem_ready = 1'b1;
    logic [AW-1:0]               imem_addr;
    logic [31:0]                 imem_wdata;
    logic                        err_illegal;
    logic                        full;
    logic [AW:0]                 word_count;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic err_exp = 1'b0;

    rv32i_program_writer #(
        .IMEM_ADDR_WIDTH (AW),
        .BASE_ADDR       (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mnemonic (in_mnemonic),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .imem_we     (imem_we),
        .imem_ready  (imem_ready),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .err_illegal (err_illegal),
        .full        (full),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every completed write must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("err_illegal", {63'd0, err_illegal}, {63'd0, err_exp});
            err_exp = 1'b0;
            if (imem_we && imem_ready) begin
                chk("write_expected", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_addr", {62'd0, imem_addr}, {62'd0, e.addr});
                    chk("wr_data", {32'd0, imem_wdata}, {32'd0, e.data});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Present one instruction and hold it until accepted (bounded wait).
    task automatic send(input RV32I_INSTRUCTION_MNEMONIC_t mn, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic legal, input logic [AW-1:0] addr, input logic [31:0] data);
        int k;
        in_valid    = 1'b1;
        in_mnemonic = mn;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        k           = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (legal) sb.push_back('{addr: addr, data: data});
        step();
        in_valid = 1'b0;
        err_exp  = !legal;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_imem_we", {63'd0, imem_we}, 64'd0);
        chk("rst_imem_addr", {62'd0, imem_addr}, 64'd0);
        chk("rst_imem_wdata", {32'd0, imem_wdata}, 64'd0);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_word_count", {61'd0, word_count}, 64'd0);
        step();
        rst_n = 1'b1;
        step();
        in_valid = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        in_valid = 1'b0;

        // Round 1: single addi
        pulse_start();
        send(ADDI, 5'd1, 5'd2, 5'd0, -32'sd1, 1'b1, 2'd0, 32'hFFF10093);
        @(negedge clk);
        chk("r1_imem_we", {63'd0, imem_we}, 64'd1);
        chk("r1_word_count", {61'd0, word_count}, 64'd1);
        step();

        // start together with a valid input: start wins
        in_valid = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        chk("start_blocks_ready", {63'd0, in_ready}, 64'd0);
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("start_clears_count", {61'd0, word_count}, 64'd0);
        step();

        // Round 2: back-to-back, then illegal inputs, then last address
        send(SW, 5'd0, 5'd2, 5'd5, 32'd8, 1'b1, 2'd0, 32'h00512423);
        send(BEQ, 5'd0, 5'd0, 5'd0, -32'sd4, 1'b1, 2'd1, 32'hFE000EE3);
        send(LUI, 5'd3, 5'd0, 5'd0, 32'h12345000, 1'b1, 2'd2, 32'h123451B7);
        send(ADDI, 5'd1, 5'd2, 5'd0, 32'd2048, 1'b0, 2'd0, 32'h0);
        send(BEQ, 5'd0, 5'd0, 5'd0, 32'd3, 1'b0, 2'd0, 32'h0);
        send(SLLI, 5'd1, 5'd1, 5'd0, 32'd32, 1'b0, 2'd0, 32'h0);
        send(LUI, 5'd1, 5'd0, 5'd0, 32'h12345001, 1'b0, 2'd0, 32'h0);
        send(JAL, 5'd1, 5'd0, 5'd0, 32'h00100000, 1'b0, 2'd0, 32'h0);
        send(NULL, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 2'd0, 32'h0);
        @(negedge clk);
        chk("illegal_count_kept", {61'd0, word_count}, 64'd3);
        step();
        send(ADD, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1, 2'd3, 32'h003100B3);
        @(negedge clk);
        chk("full_rises", {63'd0, full}, 64'd1);
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_count", {61'd0, word_count}, 64'd4);
        step();
        in_valid    = 1'b1;
        in_mnemonic = ADDI;
        repeat (3) begin
            @(negedge clk);
            chk("full_blocks_fifth", {63'd0, in_ready}, 64'd0);
            step();
        end
        in_valid = 1'b0;

        // Round 3: restart, stall the memory, then fill again
        pulse_start();
        @(negedge clk);
        chk("restart_full_low", {63'd0, full}, 64'd0);
        step();
        imem_ready = 1'b0;
        send(SRAI, 5'd4, 5'd5, 5'd0, 32'd3, 1'b1, 2'd0, 32'h4032D213);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            chk("stall_we", {63'd0, imem_we}, 64'd1);
            chk("stall_addr", {62'd0, imem_addr}, 64'd0);
            chk("stall_data", {32'd0, imem_wdata}, 64'h4032D213);
            step();
        end
        imem_ready = 1'b1;
        send(SUB, 5'd6, 5'd7, 5'd8, 32'h0, 1'b1, 2'd1, 32'h40838333);
        send(ECALL, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1, 2'd2, 32'h00000073);
        send(JAL, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 2'd3, 32'h008000EF);
        step();
        step();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("r3_full", {63'd0, full}, 64'd1);

        // Round 4: async reset while a write is pending
        pulse_start();
        imem_ready = 1'b0;
        send(JALR, 5'd1, 5'd5, 5'd0, 32'h0, 1'b1, 2'd0, 32'h000280E7);
        chk("pending_we", {63'd0, imem_we}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we", {63'd0, imem_we}, 64'd0);
        chk("arst_addr", {62'd0, imem_addr}, 64'd0);
        chk("arst_wdata", {32'd0, imem_wdata}, 64'd0);
        chk("arst_count", {61'd0, word_count}, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("arst_state", {62'd0, dut.state}, {62'd0, IDLE});
        sb.delete();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
